addr_mapper: RTL and testbench
==============================

ADDR_MAPPER -- requirements
Module: addr_mapper

Interface
REQ-001 SHALL have parameter ROW_BITS, 8, row address width.
REQ-002 SHALL have parameter COL_BITS, 4, column address width.
REQ-003 SHALL have parameter PADDR_BITS, 19, physical address width; must be at least ROW_BITS+COL_BITS+BG_BITS+BA_BITS.
REQ-004 SHALL have parameter BANK_GROUPS, 4, bank group count (power of 2).
REQ-005 SHALL have parameter BANKS_PER_GROUP, 2, banks per group (power of 2); BG_BITS and BA_BITS are the clog2 of these.
REQ-006 SHALL have port clk_in, input, 1, the single clock.
REQ-007 SHALL have port rst_n_in, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port mode_in, input, 1, mapping select: 0 = ROW|BG|BA|COL, 1 = ROW|COL|BG|BA (bank-interleaved).
REQ-009 SHALL have ports req_valid_in (input, 1), req_ready_out (output, 1), addr_in (input, PADDR_BITS) and write_in (input, 1) forming the request handshake.
REQ-010 SHALL have ports out_valid_out (output, 1) and out_ready_in (input, 1) forming the decoded-output handshake.
REQ-011 SHALL have ports row_out (ROW_BITS), col_out (COL_BITS), bg_out (BG_BITS), ba_out (BA_BITS) and write_out (1), all outputs carrying the decoded fields.
REQ-012 SHALL have outputs row_hit_out (1) and row_conflict_out (1) giving the open-row status of the target bank.
REQ-013 SHALL have inputs precharge_in (1), pre_bg_in (BG_BITS) and pre_ba_in (BA_BITS) to close one bank.

Function
REQ-014 SHALL accept a request on a cycle where req_valid_in and req_ready_out are both high, sampling mode_in together with addr_in.
REQ-015 SHALL drive req_ready_out = !out_valid_out || out_ready_in, giving full throughput with one output register.
REQ-016 SHALL present the decoded fields exactly 1 cycle after acceptance, and hold them stable while out_valid_out && !out_ready_in.
REQ-017 SHALL, in mode 0, map col=addr[COL-1:0], ba above it, bg above that, and row above bg.
REQ-018 SHALL, in mode 1, map ba=addr[BA-1:0], bg above it, col above that, and row above col.
REQ-019 SHALL ignore address bits at or above ROW_BITS+COL_BITS+BG_BITS+BA_BITS.
REQ-020 SHALL keep one open-row table entry {valid, row} for each of the BANK_GROUPS*BANKS_PER_GROUP banks.
REQ-021 SHALL drive row_hit_out and row_conflict_out combinationally from the output register and the table:
- hit = entry valid && row equal.
- conflict = entry valid && row differs.
- neither when the entry is invalid.
- both are 0 when out_valid_out=0.
REQ-022 SHALL, on each output handshake, write {1, row_out} into the target bank's entry at the next clock edge, so the following entry sees it.
REQ-023 SHALL, on precharge_in, clear the valid bit of entry {pre_bg_in, pre_ba_in}.
REQ-024 SHALL give the handshake update priority over a precharge to the same bank in the same cycle; different banks update independently.
REQ-025 SHALL let hit/conflict follow table changes while an output is stalled; they are sampled only at the handshake.

Reset
REQ-026 SHALL, while rst_n_in=0, drive out_valid_out=0, all field outputs=0, write_out=0, and clear every table valid bit, regardless of the clock.
REQ-027 SHALL drop any in-flight entry on reset mid-operation, and drive req_ready_out=1 from the first cycle after reset release.

Configuration
REQ-028 SHALL, with ADDR_MAPPER_XOR_HASH_EN defined, produce bg_out = bg ^ row[BG-1:0] and ba_out = ba ^ row[BG+BA-1:BG], in both modes; table indexing uses the hashed bank.
REQ-029 SHALL, with ADDR_MAPPER_XOR_HASH_EN undefined, output the unhashed fields.
REQ-030 SHALL, when hashing is enabled, raise an elaboration error if ROW_BITS < BG_BITS+BA_BITS.

Structure
REQ-031 SHALL place the mapping-mode enum (MAP_RBC=0, MAP_RCB=1) and the bank-entry struct {valid, row} in package mem_map_pkg.
REQ-032 SHALL implement field extraction and hashing in a combinational sub-module addr_field_decode; addr_mapper holds the pipeline register and the table.

Verification
REQ-033 SHALL pass: mode 0, addr 0x2B5 -> row 0x05, bg 1, ba 1, col 0x5, one cycle later; no hit and no conflict after reset.
REQ-034 SHALL pass: mode 1, addr 0x2B5 -> row 0x05, bg 2, ba 1, col 0x6.
REQ-035 SHALL pass: mode 0, 0x2B5 then 0x2B6 back-to-back with out_ready_in=1 -> second output row_hit_out=1; then 0x335 -> row 0x06, row_conflict_out=1.
REQ-036 SHALL pass: out_ready_in low for 3 cycles with an output pending -> fields stable and req_ready_out=0; on release, exactly one handshake and no request lost or duplicated.
REQ-037 SHALL pass: precharge bg1/ba1 in the same cycle as a handshake to bg1/ba1 -> entry stays valid (handshake wins); precharge alone -> next access to that bank shows neither hit nor conflict.
REQ-038 SHALL pass: with ADDR_MAPPER_XOR_HASH_EN, mode 0, addr 0x2B5 -> bg 0, ba 0; rst_n_in pulsed while out_valid_out=1 -> out_valid_out falls asynchronously and the table is cleared.

Source files
------------

// File: rtl/mem_map_pkg.sv
// mem_map_pkg: mapping-mode enum and open-row table entry shared by the address mapper.
package mem_map_pkg;
    typedef enum logic {MAP_RBC = 1'b0, MAP_RCB = 1'b1} map_mode_e;
    // Entries keep a fixed-width row so the struct works for any ROW_BITS up to this limit.
    localparam int MAX_ROW_BITS = 32;
    typedef struct packed {
        logic                    valid;
        logic [MAX_ROW_BITS-1:0] row;
    } bank_entry_t;
endpackage

// File: rtl/addr_field_decode.sv
// addr_field_decode: combinational row/col/bank-group/bank extraction for both mapping modes.
// ADDR_MAPPER_XOR_HASH_EN folds low row bits into the bank-group and bank fields.
module addr_field_decode
    import mem_map_pkg::*;
#(
    parameter int ROW_BITS   = 8,
    parameter int COL_BITS   = 4,
    parameter int PADDR_BITS = 19,
    parameter int BG_BITS    = 2,
    parameter int BA_BITS    = 1
) (
    input  logic                  mode_in,
    input  logic [PADDR_BITS-1:0] addr_in,
    output logic [ROW_BITS-1:0]   row_out,
    output logic [COL_BITS-1:0]   col_out,
    output logic [BG_BITS-1:0]    bg_out,
    output logic [BA_BITS-1:0]    ba_out
);
    localparam int ROW_LSB = COL_BITS + BG_BITS + BA_BITS;
    map_mode_e          mode;
    logic [BG_BITS-1:0] bg_raw;
    logic [BA_BITS-1:0] ba_raw;
    logic               unused_addr;
    assign mode        = map_mode_e'(mode_in);
    assign unused_addr = ^addr_in;
    assign row_out     = addr_in[ROW_LSB +: ROW_BITS];
    assign col_out     = (mode == MAP_RBC) ? addr_in[0 +: COL_BITS] : addr_in[BG_BITS+BA_BITS +: COL_BITS];
    assign ba_raw      = (mode == MAP_RBC) ? addr_in[COL_BITS +: BA_BITS] : addr_in[0 +: BA_BITS];
    assign bg_raw      = (mode == MAP_RBC) ? addr_in[COL_BITS+BA_BITS +: BG_BITS] : addr_in[BA_BITS +: BG_BITS];
`ifdef ADDR_MAPPER_XOR_HASH_EN
    if (ROW_BITS < BG_BITS + BA_BITS) begin : g_row_chk
        $error("addr_field_decode: ROW_BITS must be >= BG_BITS+BA_BITS when hashing");
    end
    assign bg_out = bg_raw ^ row_out[0 +: BG_BITS];
    assign ba_out = ba_raw ^ row_out[BG_BITS +: BA_BITS];
`else
    assign bg_out = bg_raw;
    assign ba_out = ba_raw;
`endif
endmodule

// File: rtl/addr_mapper.sv
// addr_mapper: registered address decode with per-bank open-row tracking (hit/conflict).
// ADDR_MAPPER_XOR_HASH_EN selects XOR bank hashing in the decoder; the table indexes the hashed bank.
module addr_mapper
    import mem_map_pkg::*;
#(
    parameter int  ROW_BITS        = 8,
    parameter int  COL_BITS        = 4,
    parameter int  PADDR_BITS      = 19,
    parameter int  BANK_GROUPS     = 4,
    parameter int  BANKS_PER_GROUP = 2,
    localparam int BG_BITS         = $clog2(BANK_GROUPS),
    localparam int BA_BITS         = $clog2(BANKS_PER_GROUP)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  mode_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [PADDR_BITS-1:0] addr_in,
    input  logic                  write_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [ROW_BITS-1:0]   row_out,
    output logic [COL_BITS-1:0]   col_out,
    output logic [BG_BITS-1:0]    bg_out,
    output logic [BA_BITS-1:0]    ba_out,
    output logic                  write_out,
    output logic                  row_hit_out,
    output logic                  row_conflict_out,
    input  logic                  precharge_in,
    input  logic [BG_BITS-1:0]    pre_bg_in,
    input  logic [BA_BITS-1:0]    pre_ba_in
);
    localparam int IDX_BITS = BG_BITS + BA_BITS;
    localparam int NB       = BANK_GROUPS * BANKS_PER_GROUP;
    if (PADDR_BITS < ROW_BITS + COL_BITS + IDX_BITS || ROW_BITS > MAX_ROW_BITS) begin : g_param_chk
        $error("addr_mapper: PADDR_BITS too small or ROW_BITS too large");
    end
    logic                valid_q, valid_d, write_q, write_d;
    logic [ROW_BITS-1:0] row_q, row_d, dec_row;
    logic [COL_BITS-1:0] col_q, col_d, dec_col;
    logic [BG_BITS-1:0]  bg_q, bg_d, dec_bg;
    logic [BA_BITS-1:0]  ba_q, ba_d, dec_ba;
    bank_entry_t         bank_q [NB];
    bank_entry_t         bank_d [NB];
    bank_entry_t         cur;
    logic [IDX_BITS-1:0] cur_idx, pre_idx;
    logic                accept, out_hs, row_match;
    addr_field_decode #(
        .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .PADDR_BITS(PADDR_BITS),
        .BG_BITS(BG_BITS), .BA_BITS(BA_BITS)
    ) u_decode (
        .mode_in(mode_in), .addr_in(addr_in),
        .row_out(dec_row), .col_out(dec_col), .bg_out(dec_bg), .ba_out(dec_ba)
    );
    assign req_ready_out    = !valid_q || out_ready_in;
    assign accept           = req_valid_in && req_ready_out;
    assign out_hs           = valid_q && out_ready_in;
    assign cur_idx          = {bg_q, ba_q};
    assign pre_idx          = {pre_bg_in, pre_ba_in};
    assign cur              = bank_q[cur_idx];
    assign row_match        = cur.row == MAX_ROW_BITS'(row_q);
    assign row_hit_out      = valid_q && cur.valid && row_match;
    assign row_conflict_out = valid_q && cur.valid && !row_match;
    assign out_valid_out    = valid_q;
    assign row_out          = row_q;
    assign col_out          = col_q;
    assign bg_out           = bg_q;
    assign ba_out           = ba_q;
    assign write_out        = write_q;
    always_comb begin
        valid_d = accept ? 1'b1 : (out_hs ? 1'b0 : valid_q);
        row_d   = accept ? dec_row : row_q;
        col_d   = accept ? dec_col : col_q;
        bg_d    = accept ? dec_bg : bg_q;
        ba_d    = accept ? dec_ba : ba_q;
        write_d = accept ? write_in : write_q;
    end
    // The handshake write is applied after the precharge clear so it wins on the same bank.
    always_comb begin
        bank_d = bank_q;
        for (int i = 0; i < NB; i++) begin
            if (precharge_in && pre_idx == IDX_BITS'(i)) bank_d[i].valid = 1'b0;
            if (out_hs && cur_idx == IDX_BITS'(i)) bank_d[i] = {1'b1, MAX_ROW_BITS'(row_q)};
        end
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            write_q <= 1'b0;
            for (int i = 0; i < NB; i++) bank_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            row_q   <= row_d;
            col_q   <= col_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            write_q <= write_d;
            bank_q  <= bank_d;
        end
    end
endmodule

// File: tb/tb_addr_mapper.sv
// tb_addr_mapper: directed and randomized checks of addr_mapper against an arithmetic reference model.
module tb_addr_mapper;
`ifdef ADDR_MAPPER_XOR_HASH_EN
    localparam bit HASH = 1'b1;
`else
    localparam bit HASH = 1'b0;
`endif
    localparam int NR = 256, NC = 16, NBG = 4, NBA = 2;
    localparam int M0_BG = HASH ? 0 : 1, M0_BA = HASH ? 0 : 1;
    localparam int M1_BG = HASH ? 3 : 2, M1_BA = HASH ? 0 : 1;
    logic        clk_in = 1'b0, rst_n_in = 1'b1;
    logic        mode_in = 1'b0, req_valid_in = 1'b0, write_in = 1'b0, out_ready_in = 1'b1, precharge_in = 1'b0;
    logic [18:0] addr_in = '0;
    logic [1:0]  pre_bg_in = '0;
    logic [0:0]  pre_ba_in = '0;
    logic        req_ready_out, out_valid_out, write_out, row_hit_out, row_conflict_out;
    logic [7:0]  row_out;
    logic [3:0]  col_out;
    logic [1:0]  bg_out;
    logic [0:0]  ba_out;
    typedef struct {int row; int col; int bg; int ba; bit wr;} fld_t;
    fld_t exp_q[$];
    bit   tbl_v[8];
    int   tbl_row[8];
    int   tests = 0, fails = 0;
    addr_mapper dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .mode_in(mode_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .addr_in(addr_in), .write_in(write_in),
        .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
        .row_out(row_out), .col_out(col_out), .bg_out(bg_out), .ba_out(ba_out),
        .write_out(write_out), .row_hit_out(row_hit_out), .row_conflict_out(row_conflict_out),
        .precharge_in(precharge_in), .pre_bg_in(pre_bg_in), .pre_ba_in(pre_ba_in)
    );
    always #5 clk_in = ~clk_in;
    function automatic fld_t decode(int unsigned a, bit m, bit w);
        fld_t f;
        f.row = int'((a / (NC * NBA * NBG)) % NR);
        if (!m) begin
            f.col = int'(a % NC);
            f.ba  = int'((a / NC) % NBA);
            f.bg  = int'((a / (NC * NBA)) % NBG);
        end else begin
            f.ba  = int'(a % NBA);
            f.bg  = int'((a / NBA) % NBG);
            f.col = int'((a / (NBA * NBG)) % NC);
        end
        if (HASH) begin
            f.bg = f.bg ^ (f.row % NBG);
            f.ba = f.ba ^ ((f.row / NBG) % NBA);
        end
        f.wr = w;
        return f;
    endfunction
    function automatic logic [15:0] pack(fld_t f);
        return {8'(f.row), 4'(f.col), 2'(f.bg), 1'(f.ba), f.wr};
    endfunction
    task automatic drive_idle();
        req_valid_in = 1'b0; write_in = 1'b0; out_ready_in = 1'b1; precharge_in = 1'b0; mode_in = 1'b0;
    endtask
    task automatic model_clear();
        exp_q.delete();
        foreach (tbl_v[i]) tbl_v[i] = 1'b0;
    endtask
    task automatic reset_dut();
        rst_n_in = 1'b0;
        model_clear();
        drive_idle();
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask
    // One clock: update the model from the inputs present now, then move to the next falling edge.
    task automatic advance();
        bit   hs, acc;
        fld_t f;
        hs  = exp_q.size() > 0 && out_ready_in;
        acc = req_valid_in && (exp_q.size() == 0 || out_ready_in);
        if (precharge_in) tbl_v[int'(pre_bg_in) * NBA + int'(pre_ba_in)] = 1'b0;
        if (hs) begin
            f = exp_q.pop_front();
            tbl_v[f.bg * NBA + f.ba]   = 1'b1;
            tbl_row[f.bg * NBA + f.ba] = f.row;
        end
        if (acc) exp_q.push_back(decode(int'(addr_in), mode_in, write_in));
        @(posedge clk_in);
        @(negedge clk_in);
    endtask
    task automatic send(logic [18:0] a, bit m);
        req_valid_in = 1'b1; addr_in = a; mode_in = m; write_in = a[0];
    endtask
    task automatic test_reset();
        #1 rst_n_in = 1'b0;
        model_clear();
        drive_idle();
        #1 tests++;
        if ({out_valid_out, row_out, col_out, bg_out, ba_out, write_out, row_hit_out, row_conflict_out} !== '0) begin
            fails++; $display("FAIL reset_outputs: got valid=%b row=%h col=%h bg=%h ba=%h wr=%b expected all zero",
                out_valid_out, row_out, col_out, bg_out, ba_out, write_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1 tests++;
        if (req_ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready_out); end
        @(negedge clk_in);
    endtask
    task automatic test_mode(bit m, int e_col, int e_bg, int e_ba);
        reset_dut();
        send(19'h2B5, m);
        advance();
        req_valid_in = 1'b0; mode_in = !m;
        #1 tests++;
        if ({out_valid_out, row_out, col_out, bg_out, ba_out, write_out} !== {1'b1, 8'h05, 4'(e_col), 2'(e_bg), 1'(e_ba), 1'b1}) begin
            fails++; $display("FAIL mode%0d_fields: got v=%b row=%h col=%h bg=%h ba=%h wr=%b expected v=1 row=05 col=%h bg=%0d ba=%0d wr=1",
                m, out_valid_out, row_out, col_out, bg_out, ba_out, write_out, e_col, e_bg, e_ba);
        end
        tests++;
        if ({row_hit_out, row_conflict_out} !== 2'b00) begin
            fails++; $display("FAIL mode%0d_status: got hit=%b conf=%b expected 0 0", m, row_hit_out, row_conflict_out);
        end
        advance();
    endtask
    task automatic test_back_to_back();
        reset_dut();
        send(19'h2B5, 1'b0);
        advance();
        send(19'h2B6, 1'b0);
        advance();
        send(19'h335, 1'b0);
        #1 tests++;
        if ({out_valid_out, col_out, row_hit_out, row_conflict_out} !== {1'b1, 4'h6, 1'b1, 1'b0}) begin
            fails++; $display("FAIL b2b_hit: got v=%b col=%h hit=%b conf=%b expected v=1 col=6 hit=1 conf=0",
                out_valid_out, col_out, row_hit_out, row_conflict_out);
        end
        advance();
        req_valid_in = 1'b0;
        #1 tests++;
        if ({out_valid_out, row_out, row_hit_out, row_conflict_out} !== {1'b1, 8'h06, 1'b0, !HASH}) begin
            fails++; $display("FAIL b2b_conflict: got v=%b row=%h hit=%b conf=%b expected v=1 row=06 hit=0 conf=%b",
                out_valid_out, row_out, row_hit_out, row_conflict_out, !HASH);
        end
        advance();
        #1 tests++;
        if (out_valid_out !== 1'b0) begin fails++; $display("FAIL b2b_drain: got valid %b expected 0", out_valid_out); end
    endtask
    task automatic test_stall();
        fld_t fa, fb;
        fa = decode(32'h2B5, 1'b0, 1'b1);
        fb = decode(32'h123, 1'b0, 1'b1);
        reset_dut();
        out_ready_in = 1'b0;
        send(19'h2B5, 1'b0);
        advance();
        send(19'h123, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 tests++;
            if ({out_valid_out, req_ready_out, row_out, col_out, bg_out, ba_out, write_out} !== {1'b1, 1'b0, pack(fa)}) begin
                fails++; $display("FAIL stall_hold%0d: got v=%b rdy=%b fields=%h expected v=1 rdy=0 fields=%h",
                    i, out_valid_out, req_ready_out, {row_out, col_out, bg_out, ba_out, write_out}, pack(fa));
            end
            advance();
        end
        out_ready_in = 1'b1;
        #1 tests++;
        if (req_ready_out !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b expected 1", req_ready_out); end
        advance();
        req_valid_in = 1'b0;
        #1 tests++;
        if ({out_valid_out, row_out, col_out, bg_out, ba_out, write_out} !== {1'b1, pack(fb)}) begin
            fails++; $display("FAIL stall_next: got v=%b fields=%h expected v=1 fields=%h",
                out_valid_out, {row_out, col_out, bg_out, ba_out, write_out}, pack(fb));
        end
        advance();
        #1 tests++;
        if (out_valid_out !== 1'b0) begin fails++; $display("FAIL stall_no_dup: got valid %b expected 0", out_valid_out); end
    endtask
    task automatic test_precharge();
        reset_dut();
        send(19'h2B5, 1'b0);
        advance();
        req_valid_in = 1'b0;
        precharge_in = 1'b1; pre_bg_in = 2'(M0_BG); pre_ba_in = 1'(M0_BA);
        advance();
        precharge_in = 1'b0;
        send(19'h2B6, 1'b0);
        advance();
        req_valid_in = 1'b0;
        #1 tests++;
        if ({row_hit_out, row_conflict_out} !== 2'b10) begin
            fails++; $display("FAIL pre_hs_wins: got hit=%b conf=%b expected 1 0", row_hit_out, row_conflict_out);
        end
        advance();
        precharge_in = 1'b1;
        advance();
        precharge_in = 1'b0;
        send(19'h2B5, 1'b0);
        advance();
        req_valid_in = 1'b0;
        #1 tests++;
        if ({out_valid_out, row_hit_out, row_conflict_out} !== 3'b100) begin
            fails++; $display("FAIL pre_alone: got v=%b hit=%b conf=%b expected 1 0 0", out_valid_out, row_hit_out, row_conflict_out);
        end
        advance();
    endtask
    task automatic test_async_reset();
        reset_dut();
        send(19'h2B5, 1'b0);
        advance();
        send(19'h2B6, 1'b0);
        advance();
        req_valid_in = 1'b0; out_ready_in = 1'b0;
        #1 tests++;
        if ({out_valid_out, row_hit_out} !== 2'b11) begin
            fails++; $display("FAIL arst_pre: got v=%b hit=%b expected 1 1", out_valid_out, row_hit_out);
        end
        #2 rst_n_in = 1'b0;
        model_clear();
        #1 tests++;
        if ({out_valid_out, row_out, col_out, bg_out, ba_out, write_out} !== '0) begin
            fails++; $display("FAIL arst_async: got v=%b fields=%h expected all zero",
                out_valid_out, {row_out, col_out, bg_out, ba_out, write_out});
        end
        @(negedge clk_in);
        rst_n_in = 1'b1; out_ready_in = 1'b1;
        #1 tests++;
        if (req_ready_out !== 1'b1) begin fails++; $display("FAIL arst_ready: got %b expected 1", req_ready_out); end
        send(19'h2B5, 1'b0);
        advance();
        req_valid_in = 1'b0;
        #1 tests++;
        if ({out_valid_out, row_hit_out, row_conflict_out} !== 3'b100) begin
            fails++; $display("FAIL arst_table: got v=%b hit=%b conf=%b expected 1 0 0", out_valid_out, row_hit_out, row_conflict_out);
        end
        advance();
    endtask
    task automatic test_random();
        bit   ev, eh, ec, er;
        fld_t f;
        int   b;
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            req_valid_in = ($urandom_range(0, 3) != 0);
            addr_in      = 19'($urandom());
            mode_in      = 1'($urandom());
            write_in     = 1'($urandom());
            out_ready_in = ($urandom_range(0, 9) < 7);
            precharge_in = ($urandom_range(0, 4) == 0);
            pre_bg_in    = 2'($urandom());
            pre_ba_in    = 1'($urandom());
            #1;
            ev = exp_q.size() > 0;
            eh = 1'b0; ec = 1'b0;
            if (ev) begin
                f  = exp_q[0];
                b  = f.bg * NBA + f.ba;
                eh = tbl_v[b] && tbl_row[b] == f.row;
                ec = tbl_v[b] && tbl_row[b] != f.row;
            end
            er = !ev || out_ready_in;
            tests++;
            if ({out_valid_out, req_ready_out, row_hit_out, row_conflict_out} !== {ev, er, eh, ec}) begin
                fails++; $display("FAIL rand_status[%0d]: got v/rdy/hit/conf=%b%b%b%b expected %b%b%b%b",
                    n, out_valid_out, req_ready_out, row_hit_out, row_conflict_out, ev, er, eh, ec);
            end
            if (ev) begin
                tests++;
                if ({row_out, col_out, bg_out, ba_out, write_out} !== pack(f)) begin
                    fails++; $display("FAIL rand_fields[%0d]: got %h expected %h",
                        n, {row_out, col_out, bg_out, ba_out, write_out}, pack(f));
                end
            end
            advance();
        end
        drive_idle();
    endtask
    initial begin
        test_reset();
        test_mode(1'b0, 5, M0_BG, M0_BA);
        test_mode(1'b1, 6, M1_BG, M1_BA);
        test_back_to_back();
        test_stall();
        test_precharge();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
